hazard_ctl: RTL and testbench
=============================

HAZARD_CTL -- requirements
Module: hazard_ctl

Interface
REQ-001 SHALL have parameter MD_CYCLES, default 32, giving the mul/div unit latency in cycles (legal range 2..63).
REQ-002 SHALL have port clk  in  1  pipeline clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports id_rs_rn, id_rt_rn  in  5 each  source register numbers of the instruction in ID.
REQ-005 SHALL have ports id_use_rs, id_use_rt  in  1 each  ID instruction reads rs / rt.
REQ-006 SHALL have port id_use_hilo  in  1  ID instruction reads HI/LO or starts a mul/div.
REQ-007 SHALL have ports ex_load  in  1,  ex_we  in  1,  ex_wr_rn  in  5  EX-stage load flag, write enable and destination.
REQ-008 SHALL have port md_start  in  1  single-cycle pulse: mul/div issued from EX.
REQ-009 SHALL have ports mem_req, mem_ready  in  1 each  data-memory access in MEM and its completion.
REQ-010 SHALL have port irq  in  1  level interrupt request.
REQ-011 SHALL have outputs pause, pc_hold, id_hold, ex_bubble, irq_ack, md_busy  out  1 each, and stall_cnt  out  16.

Function
REQ-012 SHALL compute mem_stall = mem_req & ~mem_ready combinationally.
REQ-013 SHALL compute load_use = ex_load & ex_we & (ex_wr_rn != 0) & ((id_use_rs & id_rs_rn == ex_wr_rn) | (id_use_rt & id_rt_rn == ex_wr_rn)), combinationally.
REQ-014 SHALL keep a 6-bit md_cnt: on md_start, load MD_CYCLES; otherwise decrement while nonzero; md_busy = (md_cnt != 0).
REQ-015 SHALL keep md_cnt counting regardless of pause (the mul/div unit is not frozen).
REQ-016 SHALL compute hilo_stall = md_busy & id_use_hilo.
REQ-017 SHALL drive pause = mem_stall; pause freezes every pipeline register, including the forwarding register-number latches.
REQ-018 SHALL drive pc_hold = id_hold = mem_stall | load_use | hilo_stall.
REQ-019 SHALL drive ex_bubble = ~mem_stall & (load_use | hilo_stall | flush), so that no bubble is inserted while frozen.
REQ-020 SHALL implement the FSM states RUN, DRAIN, FLUSH (2-bit encoding).
REQ-021 RUN: irq=1 -> DRAIN; otherwise stay in RUN.
REQ-022 DRAIN: when ~md_busy & ~mem_stall & ~load_use -> FLUSH; otherwise stay; irq deasserting in DRAIN -> RUN, with no ack.
REQ-023 FLUSH: flush=1 and irq_ack=1 for exactly one cycle, then -> RUN unconditionally.
REQ-024 SHALL assert flush only in FLUSH; in that cycle it also forces pc_hold=id_hold=1 so the handler fetch is redirected externally.
REQ-025 SHALL increment stall_cnt by 1 in every cycle where pc_hold=1, saturating at 16'hFFFF.
REQ-026 On simultaneous md_start and md_cnt==1, the load SHALL take priority (md_cnt = MD_CYCLES).
REQ-027 When mem_stall and load_use are both true, SHALL hold pc/id with ex_bubble=0, and apply the bubble on the first cycle mem_stall clears.

Reset
REQ-028 While rst=0: FSM=RUN, md_cnt=0, stall_cnt=0, hence md_busy=0 and irq_ack=0; combinational outputs follow their inputs.
REQ-029 Reset asserted mid-DRAIN, mid-FLUSH or during a mul/div SHALL abandon the operation with no irq_ack.
REQ-030 Release of rst SHALL take effect on the first clk edge after deassertion.

Structure
REQ-031 FSM state encodings and MD_CNT_W=6 SHALL live in the shared mips789 defines file beside the FW_* codes.
REQ-032 SHALL contain one sub-module, md_timer (the md_cnt down-counter with md_busy output); all other logic is inline.
REQ-033 pause SHALL connect to the forwarding unit's cls input; no other changes to the forwarding unit.

Verification
REQ-034 ex_load=1, ex_we=1, ex_wr_rn=5, id_rs_rn=5, id_use_rs=1 -> in that cycle pc_hold=id_hold=ex_bubble=1 and stall_cnt +1; ex_wr_rn=0 -> no stall.
REQ-035 md_start at cycle 0 with MD_CYCLES=32, id_use_hilo=1 from cycle 1 -> pc_hold=1 for cycles 1..32, md_busy falls after cycle 32.
REQ-036 mem_req=1, mem_ready=0 for 3 cycles while load_use=1 -> pause=1 and ex_bubble=0 for 3 cycles, then ex_bubble=1 for 1 cycle.
REQ-037 irq=1 during md_busy with 10 cycles left -> DRAIN for 10 cycles, then irq_ack=1 for exactly one cycle, then RUN.
REQ-038 Force 70000 stall cycles -> stall_cnt saturates at 16'hFFFF; rst=0 mid-FLUSH -> irq_ack=0 immediately, state RUN.

Source files
------------

// File: rtl/hazard_ctl_pkg.sv
// Shared hazard-control definitions: FSM encodings, mul/div counter width
// and a saturating counter helper.
package hazard_ctl_pkg;

  localparam int MD_CNT_W    = 6;
  localparam int STALL_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2
  } hz_state_e;

  function automatic logic [STALL_CNT_W-1:0] sat_inc16(input logic [STALL_CNT_W-1:0] v);
    logic [STALL_CNT_W-1:0] r;
    if (v == 16'hFFFF) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/hazard_ctl_if.sv
// Pipeline <-> hazard controller signal bundle; the pipeline is the master,
// hazard_ctl the slave.
interface hazard_ctl_if;
  logic [4:0]  id_rs_rn;
  logic [4:0]  id_rt_rn;
  logic        id_use_rs;
  logic        id_use_rt;
  logic        id_use_hilo;
  logic        ex_load;
  logic        ex_we;
  logic [4:0]  ex_wr_rn;
  logic        md_start;
  logic        mem_req;
  logic        mem_ready;
  logic        irq;
  logic        pause;
  logic        pc_hold;
  logic        id_hold;
  logic        ex_bubble;
  logic        irq_ack;
  logic        md_busy;
  logic [15:0] stall_cnt;

  modport master (
    output id_rs_rn, id_rt_rn, id_use_rs, id_use_rt, id_use_hilo,
           ex_load, ex_we, ex_wr_rn, md_start, mem_req, mem_ready, irq,
    input  pause, pc_hold, id_hold, ex_bubble, irq_ack, md_busy, stall_cnt
  );

  modport slave (
    input  id_rs_rn, id_rt_rn, id_use_rs, id_use_rt, id_use_hilo,
           ex_load, ex_we, ex_wr_rn, md_start, mem_req, mem_ready, irq,
    output pause, pc_hold, id_hold, ex_bubble, irq_ack, md_busy, stall_cnt
  );
endinterface

// File: rtl/hazard_ctl_md_timer.sv
// Mul/div latency down-counter; keeps running while the pipeline is paused.
module md_timer
  import hazard_ctl_pkg::*;
#(
  parameter int MD_CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic md_start,
  output logic md_busy
);

  localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_CYCLES);

  logic [MD_CNT_W-1:0] md_cnt_r;

  // Reload wins over the decrement so back-to-back ops restart the full latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      md_cnt_r <= {MD_CNT_W{1'b0}};
    end else if (md_start) begin
      md_cnt_r <= MD_LOAD;
    end else if (md_cnt_r != {MD_CNT_W{1'b0}}) begin
      md_cnt_r <= md_cnt_r - MD_CNT_W'(1);
    end else begin
      md_cnt_r <= md_cnt_r;
    end
  end

  assign md_busy = (md_cnt_r != {MD_CNT_W{1'b0}});

endmodule

// File: rtl/hazard_ctl.sv
// Pipeline hazard controller: memory freeze, load-use and HI/LO interlocks,
// and interrupt drain/flush sequencing with a saturating stall counter.
module hazard_ctl
  import hazard_ctl_pkg::*;
#(
  parameter int MD_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  hazard_ctl_if.slave hz
);

  hz_state_e              state_r;
  hz_state_e              state_nxt_s;
  logic                   mem_stall_s;
  logic                   load_use_s;
  logic                   hilo_stall_s;
  logic                   md_busy_s;
  logic                   flush_s;
  logic                   hold_s;
  logic [STALL_CNT_W-1:0] stall_cnt_r;

  assign mem_stall_s  = hz.mem_req & ~hz.mem_ready;
  assign load_use_s   = hz.ex_load & hz.ex_we & (hz.ex_wr_rn != 5'd0) &
                        ((hz.id_use_rs & (hz.id_rs_rn == hz.ex_wr_rn)) |
                         (hz.id_use_rt & (hz.id_rt_rn == hz.ex_wr_rn)));
  assign hilo_stall_s = md_busy_s & hz.id_use_hilo;

  md_timer #(.MD_CYCLES(MD_CYCLES)) u_md_timer (
    .clk      (clk),
    .rst      (rst),
    .md_start (hz.md_start),
    .md_busy  (md_busy_s)
  );

  // Interrupt sequencer state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state; a dropped irq while draining abandons the request silently.
  always_comb begin
    state_nxt_s = state_r;
    flush_s     = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (hz.irq) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (!hz.irq) begin
          state_nxt_s = ST_RUN;
        end else if (!md_busy_s && !mem_stall_s && !load_use_s) begin
          state_nxt_s = ST_FLUSH;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_FLUSH: begin
        flush_s     = 1'b1;
        state_nxt_s = ST_RUN;
      end
      default: begin
        state_nxt_s = ST_RUN;
      end
    endcase
  end

  assign hold_s = mem_stall_s | load_use_s | hilo_stall_s | flush_s;

  // Stall statistics, saturating rather than wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_r <= 16'd0;
    end else if (hold_s) begin
      stall_cnt_r <= sat_inc16(stall_cnt_r);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  // While frozen no bubble is injected; it lands on the first unfrozen cycle.
  assign hz.pause     = mem_stall_s;
  assign hz.pc_hold   = hold_s;
  assign hz.id_hold   = hold_s;
  assign hz.ex_bubble = ~mem_stall_s & (load_use_s | hilo_stall_s | flush_s);
  assign hz.irq_ack   = flush_s;
  assign hz.md_busy   = md_busy_s;
  assign hz.stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_hazard_ctl.sv
// Self-checking bench for hazard_ctl: vector table plus multi-cycle sequences.
module tb_hazard_ctl;
  import hazard_ctl_pkg::*;

  localparam int MD_CYCLES = 32;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic       use_hilo;
    logic       ld;
    logic       we;
    logic [4:0] wr;
    logic       md_start;
    logic       mem_req;
    logic       mem_ready;
    logic       irq;
  } in_t;

  typedef struct packed {
    in_t  i;
    logic pause;
    logic hold;
    logic bubble;
  } vec_t;

  typedef struct packed {
    logic        pause;
    logic        pc_hold;
    logic        id_hold;
    logic        bubble;
    logic        ack;
    logic        busy;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctl_if bus();
  hazard_ctl #(.MD_CYCLES(MD_CYCLES)) dut (.clk(clk), .rst(rst), .hz(bus));

  exp_t sb_q[$];
  vec_t tbl[13];
  in_t  cur;
  int   n_vec   = 0;
  int   n_err   = 0;
  int   exp_cnt = 0;

  function automatic in_t mk(input logic [4:0] rs, input logic [4:0] rt,
                             input logic urs, input logic urt, input logic uhl,
                             input logic ld, input logic we, input logic [4:0] wr,
                             input logic mreq, input logic mrdy);
    in_t v;
    v = '0;
    v.rs = rs; v.rt = rt; v.use_rs = urs; v.use_rt = urt; v.use_hilo = uhl;
    v.ld = ld; v.we = we; v.wr = wr; v.mem_req = mreq; v.mem_ready = mrdy;
    return v;
  endfunction

  task automatic drive(input in_t v);
    bus.id_rs_rn    = v.rs;
    bus.id_rt_rn    = v.rt;
    bus.id_use_rs   = v.use_rs;
    bus.id_use_rt   = v.use_rt;
    bus.id_use_hilo = v.use_hilo;
    bus.ex_load     = v.ld;
    bus.ex_we       = v.we;
    bus.ex_wr_rn    = v.wr;
    bus.md_start    = v.md_start;
    bus.mem_req     = v.mem_req;
    bus.mem_ready   = v.mem_ready;
    bus.irq         = v.irq;
  endtask

  task automatic cmp(input string tag, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, want);
    end
  endtask

  // Drive cur, queue the expectation, compare at the falling edge, advance one cycle.
  task automatic step(input string tag, input logic pause, input logic hold,
                      input logic bubble, input logic ack, input logic busy);
    exp_t e;
    exp_t a;
    drive(cur);
    e.pause = pause; e.pc_hold = hold; e.id_hold = hold; e.bubble = bubble;
    e.ack = ack; e.busy = busy;
    e.cnt = (exp_cnt >= 65535) ? 16'hFFFF : 16'(exp_cnt);
    sb_q.push_back(e);
    @(negedge clk);
    e = sb_q.pop_front();
    a = {bus.pause, bus.pc_hold, bus.id_hold, bus.ex_bubble, bus.irq_ack,
         bus.md_busy, bus.stall_cnt};
    cmp(tag, 32'(a), 32'(e));
    if (hold && rst) exp_cnt++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //              rs  rt  urs  urt  uhl  ld   we   wr  mreq mrdy   pause hold bubble
    tbl[0]  = '{mk(5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 1'b0,1'b0), 1'b0,1'b0,1'b0};
    tbl[1]  = '{mk(5'd5, 5'd0, 1'b1,1'b0,1'b0,1'b1,1'b1,5'd5, 1'b0,1'b0), 1'b0,1'b1,1'b1};
    tbl[2]  = '{mk(5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b1,1'b1,5'd0, 1'b0,1'b0), 1'b0,1'b0,1'b0};
    tbl[3]  = '{mk(5'd0, 5'd7, 1'b0,1'b1,1'b0,1'b1,1'b1,5'd7, 1'b0,1'b0), 1'b0,1'b1,1'b1};
    tbl[4]  = '{mk(5'd5, 5'd0, 1'b0,1'b0,1'b0,1'b1,1'b1,5'd5, 1'b0,1'b0), 1'b0,1'b0,1'b0};
    tbl[5]  = '{mk(5'd5, 5'd0, 1'b1,1'b0,1'b0,1'b1,1'b0,5'd5, 1'b0,1'b0), 1'b0,1'b0,1'b0};
    tbl[6]  = '{mk(5'd5, 5'd0, 1'b1,1'b0,1'b0,1'b0,1'b1,5'd5, 1'b0,1'b0), 1'b0,1'b0,1'b0};
    tbl[7]  = '{mk(5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 1'b1,1'b0), 1'b1,1'b1,1'b0};
    tbl[8]  = '{mk(5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 1'b1,1'b1), 1'b0,1'b0,1'b0};
    tbl[9]  = '{mk(5'd9, 5'd9, 1'b1,1'b1,1'b0,1'b1,1'b1,5'd9, 1'b1,1'b0), 1'b1,1'b1,1'b0};
    tbl[10] = '{mk(5'd0, 5'd0, 1'b0,1'b0,1'b1,1'b0,1'b0,5'd0, 1'b0,1'b0), 1'b0,1'b0,1'b0};
    tbl[11] = '{mk(5'd3, 5'd5, 1'b1,1'b0,1'b0,1'b1,1'b1,5'd5, 1'b0,1'b0), 1'b0,1'b0,1'b0};
    tbl[12] = '{mk(5'd31,5'd31,1'b0,1'b1,1'b0,1'b1,1'b1,5'd31,1'b0,1'b1), 1'b0,1'b1,1'b1};

    rst = 1'b0;
    cur = '0;
    step("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;

    for (int k = 0; k < 13; k++) begin
      cur = tbl[k].i;
      step($sformatf("vec%0d", k), tbl[k].pause, tbl[k].hold, tbl[k].bubble, 1'b0, 1'b0);
    end

    // HI/LO interlock across the full mul/div latency
    cur = '0; cur.md_start = 1'b1;
    step("md_start", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cur.md_start = 1'b0; cur.use_hilo = 1'b1;
    for (int k = 1; k <= MD_CYCLES; k++) step($sformatf("md_hilo%0d", k), 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    step("md_done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Load-use held under a memory freeze: bubble deferred to the release cycle
    cur = mk(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) step($sformatf("mem_lu%0d", k), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cur.mem_ready = 1'b1;
    step("mem_lu_rel", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cur = '0;
    step("mem_lu_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // md_start coinciding with md_cnt==1 reloads the full latency
    cur.md_start = 1'b1;
    step("md_re0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cur.md_start = 1'b0;
    for (int k = 1; k < MD_CYCLES; k++) step($sformatf("md_re_a%0d", k), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cur.md_start = 1'b1;
    step("md_re_last", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cur.md_start = 1'b0;
    for (int k = 0; k < MD_CYCLES; k++) step($sformatf("md_re_b%0d", k), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("md_re_done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // irq with 10 mul/div cycles left: 10 drain cycles, then a single ack
    cur.md_start = 1'b1;
    step("irq_md0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cur.md_start = 1'b0;
    for (int k = 1; k < 23; k++) step($sformatf("irq_md%0d", k), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cur.irq = 1'b1;
    for (int k = 23; k < 33; k++) step($sformatf("irq_drain%0d", k), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("irq_drain_end", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("irq_ack", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    cur.irq = 1'b0;
    step("irq_post", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // irq dropped mid-drain: no acknowledge ever
    cur.md_start = 1'b1;
    step("abort_md", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cur.md_start = 1'b0; cur.irq = 1'b1;
    step("abort_irq", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cur.irq = 1'b0;
    for (int k = 2; k <= MD_CYCLES; k++) step($sformatf("abort_wait%0d", k), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("abort_idle0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("abort_idle1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Saturation of the stall counter
    cur = mk(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0);
    drive(cur);
    repeat (70000) @(posedge clk);
    exp_cnt += 70000;
    #1;
    step("sat0", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step("sat1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Reset asserted during FLUSH
    cur = '0; cur.irq = 1'b1;
    step("fl_run", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("fl_drain", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp("fl_ack", 32'(bus.irq_ack), 32'd1);
    rst = 1'b0;
    exp_cnt = 0;
    #1;
    cmp("rst_ack", 32'(bus.irq_ack), 32'd0);
    cmp("rst_hold", 32'(bus.pc_hold), 32'd0);
    cmp("rst_cnt", 32'(bus.stall_cnt), 32'd0);
    cur.irq = 1'b0;
    drive(cur);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    step("post_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
